// File: rtl/convb_controller_pkg.sv
// rtl/convb_controller_pkg.sv - convb_controller state enum and derived-size helpers
package convb_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } convb_state_t;

  function automatic int f_k2(input int k);
    return k * k;
  endfunction

  function automatic int f_ifm_size_next(input int size, input int k);
    return size - k + 1;
  endfunction

  function automatic int f_filter_passes(input int filters, input int units);
    return (filters + units - 1) / units;
  endfunction

  function automatic int f_drain_cycles(input int latency);
    return latency + 2;
  endfunction

  // Values for the default layer configuration.
  localparam int K2            = f_k2(5);
  localparam int IFM_SIZE_NEXT = f_ifm_size_next(32, 5);
  localparam int FILTER_PASSES = f_filter_passes(6, 3);
  localparam int DRAIN_CYCLES  = f_drain_cycles(1);

endpackage

// File: rtl/convb_controller_if.sv
// rtl/convb_controller_if.sv - start/done handshake, memory strobes/addresses and unit enables
interface convb_controller_if #(
  parameter int ADDRESS_BITS = 15
) ();
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    wm_enable_read;
  logic [ADDRESS_BITS-1:0] wm_address;
  logic                    wm_fifo_enable;
  logic                    ifm_enable_read;
  logic [ADDRESS_BITS-1:0] ifm_address;
  logic                    ifm_fifo_enable;
  logic                    conv_enable;
  logic                    accu_enable;
  logic                    accu_first;
  logic                    relu_enable;
  logic                    next_enable_read;
  logic [ADDRESS_BITS-1:0] next_address;
  logic                    ofm_write_enable;
  logic [ADDRESS_BITS-1:0] ofm_address;

  modport master (
    input  start,
    output busy, done, wm_enable_read, wm_address, wm_fifo_enable,
           ifm_enable_read, ifm_address, ifm_fifo_enable, conv_enable,
           accu_enable, accu_first, relu_enable, next_enable_read,
           next_address, ofm_write_enable, ofm_address
  );

  modport slave (
    output start,
    input  busy, done, wm_enable_read, wm_address, wm_fifo_enable,
           ifm_enable_read, ifm_address, ifm_fifo_enable, conv_enable,
           accu_enable, accu_first, relu_enable, next_enable_read,
           next_address, ofm_write_enable, ofm_address
  );
endinterface

// File: rtl/convb_controller_window_tracker.sv
// rtl/convb_controller_window_tracker.sv - row/column of each pushed IFM pixel, flags full KxK windows
module convb_window_tracker #(
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_push,
  output logic o_window_valid
);
  localparam int CW = $clog2(IFM_SIZE + 1);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_push) begin
      if (r_col == CW'(IFM_SIZE - 1)) begin
        r_col <= '0;
        r_row <= (r_row == CW'(IFM_SIZE - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_window_valid = i_push && (r_row >= CW'(KERNAL_SIZE - 1)) &&
                          (r_col >= CW'(KERNAL_SIZE - 1));
endmodule

// File: rtl/convb_controller.sv
// rtl/convb_controller.sv - ConvB layer sequencer; CONVB_CTRL_CYCLE_COUNT_EN adds cycle_count
module convb_controller
  import convb_ctrl_pkg::*;
#(
  parameter int ADDRESS_BITS      = 15,
  parameter int IFM_SIZE          = 32,
  parameter int IFM_DEPTH         = 3,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 6,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int CONV_LATENCY      = 1
) (
  input  logic clk,
  input  logic reset,
`ifdef CONVB_CTRL_CYCLE_COUNT_EN
  output logic [31:0] cycle_count,
`endif
  convb_controller_if.master bus
);
  localparam int CFG_K2    = f_k2(KERNAL_SIZE);
  localparam int CFG_PIX   = IFM_SIZE * IFM_SIZE;
  localparam int CFG_NSZ   = f_ifm_size_next(IFM_SIZE, KERNAL_SIZE);
  localparam int CFG_OUT   = CFG_NSZ * CFG_NSZ;
  localparam int CFG_FP    = f_filter_passes(NUMBER_OF_FILTERS, NUMBER_OF_UNITS);
  localparam int CFG_DRAIN = f_drain_cycles(CONV_LATENCY);
  localparam int NXT_TAP   = (CONV_LATENCY == 0) ? 0 : CONV_LATENCY - 1;
  localparam int ACC_TAP   = CONV_LATENCY;
  localparam int OFM_TAP   = CONV_LATENCY + 1;
  localparam int STEP_MAX  = (CFG_PIX > CFG_DRAIN) ? ((CFG_PIX > CFG_K2) ? CFG_PIX : CFG_K2)
                                                   : ((CFG_DRAIN > CFG_K2) ? CFG_DRAIN : CFG_K2);
  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int DW = $clog2(IFM_DEPTH + 1);
  localparam int FW = $clog2(CFG_FP + 1);
  localparam int OW = $clog2(CFG_OUT + 1);
  localparam longint ADDR_SPAN = 64'd1 << ADDRESS_BITS;

  typedef logic [ADDRESS_BITS-1:0] addr_t;

  if (longint'(CFG_FP) * IFM_DEPTH * CFG_K2 > ADDR_SPAN ||
      longint'(IFM_DEPTH) * CFG_PIX > ADDR_SPAN ||
      longint'(CFG_FP) * CFG_OUT > ADDR_SPAN) begin : g_addr_overflow
    $error("convb_controller: address range does not fit ADDRESS_BITS");
  end

  convb_state_t r_state, w_state_next;
  logic [SW-1:0] r_step;   // k in LOAD_W, p in STREAM, drain count in DRAIN
  logic [DW-1:0] r_d;
  logic [FW-1:0] r_f;
  logic [OW-1:0] r_o;
  logic          r_wm_fifo, r_ifm_fifo;
  logic [OFM_TAP:0] r_en_sr;
  addr_t         r_addr_sr [1:OFM_TAP];
  addr_t         w_addr_tap [0:OFM_TAP];
  logic          w_last_step, w_last_pair, w_wm_rd, w_ifm_rd, w_window_valid, w_idle;
  addr_t         w_wm_addr, w_ifm_addr, w_out_addr;

  assign w_idle      = (r_state == S_IDLE);
  assign w_last_step = ((r_state == S_LOAD_W) && (r_step == SW'(CFG_K2))) ||
                       ((r_state == S_STREAM) && (r_step == SW'(CFG_PIX))) ||
                       ((r_state == S_DRAIN)  && (r_step == SW'(CFG_DRAIN - 1)));
  assign w_last_pair = (r_d == DW'(IFM_DEPTH - 1)) && (r_f == FW'(CFG_FP - 1));
  assign w_wm_rd     = (r_state == S_LOAD_W) && (r_step < SW'(CFG_K2));
  assign w_ifm_rd    = (r_state == S_STREAM) && (r_step < SW'(CFG_PIX));
  assign w_wm_addr   = (addr_t'(r_f) * addr_t'(IFM_DEPTH) + addr_t'(r_d)) * addr_t'(CFG_K2)
                     + addr_t'(r_step);
  assign w_ifm_addr  = addr_t'(r_d) * addr_t'(CFG_PIX) + addr_t'(r_step);
  assign w_out_addr  = addr_t'(r_f) * addr_t'(CFG_OUT) + addr_t'(r_o);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start)   w_state_next = S_LOAD_W;
      S_LOAD_W: if (w_last_step) w_state_next = S_STREAM;
      S_STREAM: if (w_last_step) w_state_next = S_DRAIN;
      S_DRAIN:  if (w_last_step) w_state_next = S_NEXT;
      S_NEXT:   w_state_next = w_last_pair ? S_DONE : S_LOAD_W;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_d     <= '0;
      r_f     <= '0;
    end else begin
      r_state <= w_state_next;
      r_step  <= (w_idle || (w_state_next != r_state)) ? '0 : r_step + 1'b1;
      if (r_state == S_NEXT) begin
        if (r_d == DW'(IFM_DEPTH - 1)) begin
          r_d <= '0;
          r_f <= (r_f == FW'(CFG_FP - 1)) ? '0 : r_f + 1'b1;
        end else begin
          r_d <= r_d + 1'b1;
        end
      end
    end
  end

  convb_window_tracker #(
    .IFM_SIZE    (IFM_SIZE),
    .KERNAL_SIZE (KERNAL_SIZE)
  ) u_window_tracker (
    .clk            (clk),
    .reset          (reset),
    .i_clear        (w_idle),
    .i_push         (r_ifm_fifo),
    .o_window_valid (w_window_valid)
  );

  // Tap j of the enable/address lines is conv_enable and its output address j cycles late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wm_fifo  <= 1'b0;
      r_ifm_fifo <= 1'b0;
      r_en_sr    <= '0;
      r_o        <= '0;
      for (int j = 1; j <= OFM_TAP; j++) r_addr_sr[j] <= '0;
    end else begin
      r_wm_fifo    <= w_wm_rd;
      r_ifm_fifo   <= w_ifm_rd;
      r_en_sr      <= {r_en_sr[OFM_TAP-1:0], w_window_valid};
      r_addr_sr[1] <= w_out_addr;
      for (int j = 2; j <= OFM_TAP; j++) r_addr_sr[j] <= r_addr_sr[j-1];
      if (w_idle)          r_o <= '0;
      else if (r_en_sr[0]) r_o <= (r_o == OW'(CFG_OUT - 1)) ? '0 : r_o + 1'b1;
    end
  end

  always_comb begin
    w_addr_tap[0] = w_out_addr;
    for (int j = 1; j <= OFM_TAP; j++) w_addr_tap[j] = r_addr_sr[j];
  end

  assign bus.busy             = !w_idle;
  assign bus.done             = (r_state == S_DONE);
  assign bus.wm_enable_read   = w_wm_rd;
  assign bus.wm_address       = w_wm_rd ? w_wm_addr : '0;
  assign bus.wm_fifo_enable   = r_wm_fifo;
  assign bus.ifm_enable_read  = w_ifm_rd;
  assign bus.ifm_address      = w_ifm_rd ? w_ifm_addr : '0;
  assign bus.ifm_fifo_enable  = r_ifm_fifo;
  assign bus.conv_enable      = r_en_sr[0];
  assign bus.next_enable_read = r_en_sr[NXT_TAP];
  assign bus.next_address     = r_en_sr[NXT_TAP] ? w_addr_tap[NXT_TAP] : '0;
  assign bus.accu_enable      = r_en_sr[ACC_TAP];
  assign bus.accu_first       = r_en_sr[ACC_TAP] && (r_d == '0);
  assign bus.relu_enable      = r_en_sr[ACC_TAP] && (r_d == DW'(IFM_DEPTH - 1));
  assign bus.ofm_write_enable = r_en_sr[OFM_TAP];
  assign bus.ofm_address      = r_en_sr[OFM_TAP] ? w_addr_tap[OFM_TAP] : '0;

`ifdef CONVB_CTRL_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_cycle_count <= '0;
    else if (w_idle && bus.start) r_cycle_count <= '0;
    else if (!w_idle)             r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign cycle_count = r_cycle_count;
`endif
endmodule

// File: doc/convb_controller.md
# convb_controller

Sequencer for one or more `ConvB_unit` datapaths in a layer. It runs the weight-memory/weight-FIFO load, the IFM streaming, and the conv/accumulate/ReLU enable pulses for every (filter pass, input channel) pair. It also generates the IFM, partial-sum and OFM memory addresses. It sits between the top-level layer FSM (start/done) and the unit array, and all units are driven in lockstep.

## Interface
Parameters:
- `ADDRESS_BITS`, 15, width of every address output
- `IFM_SIZE`, 32, IFM side length
- `IFM_DEPTH`, 3, input channels
- `KERNAL_SIZE`, 5, kernel side length
- `NUMBER_OF_FILTERS`, 6, total filters in the layer
- `NUMBER_OF_UNITS`, 3, parallel units. `FILTER_PASSES = ceil(NUMBER_OF_FILTERS/NUMBER_OF_UNITS)`
- `CONV_LATENCY`, 1, cycles from `conv_enable` to valid `conv_data_out`

Ports:
- `clk`, in, 1, single clock. All logic is on the rising edge.
- `reset`, in, 1, asynchronous, active-low
- `start`, in, 1, level sampled in IDLE. Begins a full layer run.
- `busy`, out, 1, high from the cycle after `start` is accepted until `done`
- `done`, out, 1, one-cycle pulse at the end of the layer
- `wm_enable_read`, out, 1, weight-memory read strobe
- `wm_address`, out, `ADDRESS_BITS`, weight address
- `wm_fifo_enable`, out, 1, weight-FIFO shift
- `ifm_enable_read`, out, 1, IFM read strobe
- `ifm_address`, out, `ADDRESS_BITS`, IFM address
- `ifm_fifo_enable`, out, 1, IFM window-FIFO shift
- `conv_enable`, out, 1, to units
- `accu_enable`, out, 1, to units
- `accu_first`, out, 1, high with `accu_enable` on channel 0. Top level uses it to select bias over the partial sum.
- `relu_enable`, out, 1, high with `accu_enable` on the last channel
- `next_enable_read`, out, 1, partial-sum read strobe
- `next_address`, out, `ADDRESS_BITS`, partial-sum read address
- `ofm_write_enable`, out, 1, OFM/partial-sum write strobe
- `ofm_address`, out, `ADDRESS_BITS`, OFM/partial-sum write address

## Operation
- States: IDLE → LOAD_W → STREAM → DRAIN → NEXT → (LOAD_W | DONE) → IDLE.
- Loops: filter pass `f` is the outer loop over 0..FILTER_PASSES-1. Channel `d` is the inner loop over 0..IFM_DEPTH-1.
- LOAD_W:
  - Counter `k` runs 0..K²-1 with `wm_enable_read`=1 and `wm_address = (f*IFM_DEPTH+d)*K² + k`.
  - `wm_fifo_enable` is `wm_enable_read` delayed 1 cycle (memory read latency).
  - The state lasts K²+1 cycles.
- STREAM:
  - Pixel counter `p` runs 0..IFM_SIZE²-1 with `ifm_enable_read`=1 and `ifm_address = d*IFM_SIZE² + p`.
  - `ifm_fifo_enable` is `ifm_enable_read` delayed 1 cycle.
  - The pushed pixel `q` (`p` delayed 1) has row `r` and column `c`. The window is valid when r≥K-1 and c≥K-1.
  - `conv_enable` is asserted the cycle after a valid push.
- Each `conv_enable` increments the output counter `o` over 0..IFM_SIZE_NEXT²-1 in raster order. `IFM_SIZE_NEXT = IFM_SIZE-K+1`.
- Partial-sum and OFM addressing: `next_address = ofm_address = f*IFM_SIZE_NEXT² + o`.
- DRAIN: waits `CONV_LATENCY+2` cycles until the last write has issued.
- NEXT: `d++`. On wrap, `d` returns to 0 and `f++`. After the last `f`, go to DONE, which pulses `done` and returns to IDLE.
- Arithmetic:
  - Counters are unsigned and sized with `$clog2`.
  - Address products are computed in `ADDRESS_BITS`. Overflow is a configuration error, caught by an elaboration-time assertion.
- Boundary conditions:
  - `start` while busy is ignored.
  - `start` held high after `done` begins a new run on the cycle IDLE is re-entered.
  - `reset` low at any time returns to IDLE within the same cycle (async) and clears all counters and delay lines. Partial results are discarded.

## Timing
- Reset value of every output is 0.
- `start` accepted at edge N: `busy`=1 and LOAD_W begin at N+1.
- Per-output pipeline, relative to `conv_enable` at cycle t:
  - `next_enable_read` at t+CONV_LATENCY-1. With CONV_LATENCY=0, it is at t, and `next` is read combinationally.
  - `accu_enable`, `accu_first` and `relu_enable` at t+CONV_LATENCY.
  - `ofm_write_enable` at t+CONV_LATENCY+1, with `ofm_address` for that output.
- Cycles per (f,d) pair: (K²+1) + (IFM_SIZE²+1) + (CONV_LATENCY+2) + 1.
- Total layer time: FILTER_PASSES·IFM_DEPTH·(that) + 1 (DONE).

## Configuration
- Macro `CONVB_CTRL_CYCLE_COUNT_EN`.
- Defined: adds output `cycle_count` (32 bits). It clears on accepted `start`, increments every cycle `busy`=1, and holds after `done`. Reset value is 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `convb_ctrl_pkg` holds:
  - the state enum `convb_state_t`
  - `localparam` helpers: `K2`, `IFM_SIZE_NEXT`, `FILTER_PASSES`, `DRAIN_CYCLES`
- One sub-module `convb_window_tracker` takes the push strobe, tracks row/column of the pushed pixel, and outputs `window_valid`. It is instantiated once.
- Enable/address delay lines are small shift registers in the top module.

## Test plan
Unless noted, the configuration is IFM_SIZE=6, K=3, IFM_DEPTH=2, NUMBER_OF_FILTERS=2, NUMBER_OF_UNITS=1, CONV_LATENCY=1.
- Full run, single `start`:
  - Exactly 64 `conv_enable` pulses.
  - 32 `relu_enable` and 32 `accu_first` pulses.
  - 64 `ofm_write_enable` pulses.
  - `done` once, after 4·(10+37+3+1)+1=205 cycles of `busy`.
- Weight addresses:
  - LOAD_W sequences are 0..8, 9..17, 18..26, 27..35.
  - `wm_fifo_enable` lags `wm_enable_read` by exactly 1 cycle.
- Window gating:
  - On channel 0, the first `conv_enable` is the cycle after pixel 14 is pushed.
  - No pulses occur for columns 0–1 or rows 0–1. `ofm_address` runs 0..15, then 16..31 on f=1.
- Pipeline alignment: `accu_enable` is 1 cycle after `conv_enable`, and `ofm_write_enable` is 2 cycles after it, each with matching address.
- Reset mid-STREAM:
  - All outputs go to 0 asynchronously. The FSM is in IDLE.
  - A subsequent `start` reproduces the full-run counts exactly.
- `start` pulsed while `busy`: no effect on counts or timing. With `CONVB_CTRL_CYCLE_COUNT_EN`, `cycle_count`=205 at `done`.
